// File: rtl/rattlesnake_instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC and issues one memory read per
// controller fetch request. The returned word goes to decode as a one-cycle
// enable pulse. Redirects move the PC in either state. A redirect that lands
// while a read is outstanding causes the in-flight word to be dropped.
module rattlesnake_instruction_fetch #(
  parameter int                     XLEN        = 32,
  parameter int                     PC_BITWIDTH = 32,
  parameter logic [PC_BITWIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   fetch_enable,
  input  logic                   jump_strobe,
  input  logic [PC_BITWIDTH-1:0] jump_addr,
  output logic                   mem_read_en,
  output logic [PC_BITWIDTH-1:0] mem_addr,
  input  logic                   mem_read_ack,
  input  logic [XLEN-1:0]        mem_data,
  output logic                   enable_out,
  output logic [XLEN-1:0]        IR_out,
  output logic [XLEN-1:0]        IR_original_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   exception_misaligned,
  output logic                   exception_illegal,
  output logic                   busy
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t                   state;
  logic [PC_BITWIDTH-1:0]   pc;
  logic [PC_BITWIDTH-1:0]   fetch_addr;
  logic                     pending;
  logic                     discard;
  logic [PC_BITWIDTH-1:0]   target;

  // A redirect arriving with the request fetches from the new target directly.
  always_comb target = jump_strobe ? jump_addr : pc;

  // Fetch controller: state, PC bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      pc                   <= RESET_PC;
      fetch_addr           <= '0;
      pending              <= 1'b0;
      discard              <= 1'b0;
      mem_read_en          <= 1'b0;
      mem_addr             <= '0;
      enable_out           <= 1'b0;
      IR_out               <= '0;
      IR_original_out      <= '0;
      PC_out               <= '0;
      exception_misaligned <= 1'b0;
      exception_illegal    <= 1'b0;
      busy                 <= 1'b0;
    end else if (sync_reset) begin
      state                <= IDLE;
      pc                   <= RESET_PC;
      fetch_addr           <= '0;
      pending              <= 1'b0;
      discard              <= 1'b0;
      mem_read_en          <= 1'b0;
      mem_addr             <= '0;
      enable_out           <= 1'b0;
      IR_out               <= '0;
      IR_original_out      <= '0;
      PC_out               <= '0;
      exception_misaligned <= 1'b0;
      exception_illegal    <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      mem_read_en          <= 1'b0;
      enable_out           <= 1'b0;
      exception_misaligned <= 1'b0;
      exception_illegal    <= 1'b0;
      if (jump_strobe) pc <= jump_addr;
      case (state)
        IDLE: begin
          if (fetch_enable || pending) begin
            pending <= 1'b0;
            if (target[1:0] != 2'b00) begin
              exception_misaligned <= 1'b1;
            end else begin
              mem_read_en <= 1'b1;
              mem_addr    <= target;
              fetch_addr  <= target;
              state       <= WAIT_ACK;
              busy        <= 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          // Only one request is remembered; extras are absorbed.
          if (fetch_enable) pending <= 1'b1;
          if (mem_read_ack) begin
            state   <= IDLE;
            busy    <= 1'b0;
            discard <= 1'b0;
            // A redirect coinciding with the ack drops the word just like
            // an earlier one; the PC already takes jump_addr above.
            if (!discard && !jump_strobe) begin
              enable_out      <= 1'b1;
              IR_original_out <= mem_data;
              PC_out          <= fetch_addr;
              pc              <= fetch_addr + PC_BITWIDTH'(4);
              if (mem_data[1:0] == 2'b11) begin
                IR_out <= mem_data;
              end else begin
                IR_out            <= NOP;
                exception_illegal <= 1'b1;
              end
            end
          end else if (jump_strobe) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rattlesnake_instruction_fetch.sv
// Directed bench for the fetch stage: a cycle-by-cycle vector table for the
// single-request scenarios, plus a burst sequence driven by a small
// latency-4 memory responder.
module tb_rattlesnake_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n, sync_reset, fetch_enable, jump_strobe;
  logic [31:0] jump_addr;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic        mem_read_ack;
  logic [31:0] mem_data;
  logic        enable_out;
  logic [31:0] IR_out, IR_original_out, PC_out;
  logic        exception_misaligned, exception_illegal, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int row;

  always #5 clk = ~clk;

  rattlesnake_instruction_fetch #(
    .XLEN(32), .PC_BITWIDTH(32), .RESET_PC(32'h0000_0080)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .fetch_enable(fetch_enable), .jump_strobe(jump_strobe), .jump_addr(jump_addr),
    .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_read_ack(mem_read_ack), .mem_data(mem_data),
    .enable_out(enable_out), .IR_out(IR_out), .IR_original_out(IR_original_out),
    .PC_out(PC_out), .exception_misaligned(exception_misaligned),
    .exception_illegal(exception_illegal), .busy(busy)
  );

  typedef struct {
    logic        fe, js;
    logic [31:0] ja;
    logic        sr, ack;
    logic [31:0] data;
    logic        rd;
    logic [31:0] addr;
    logic        en;
    logic [31:0] ir, iro, pc;
    logic        bsy, mis, ill;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t v(logic fe, logic js, logic [31:0] ja, logic sr, logic ack,
                             logic [31:0] data, logic rd, logic [31:0] addr, logic en,
                             logic [31:0] ir, logic [31:0] iro, logic [31:0] pc,
                             logic bsy, logic mis, logic ill);
    vec_t r;
    r.fe = fe; r.js = js; r.ja = ja; r.sr = sr; r.ack = ack; r.data = data;
    r.rd = rd; r.addr = addr; r.en = en; r.ir = ir; r.iro = iro; r.pc = pc;
    r.bsy = bsy; r.mis = mis; r.ill = ill;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h80:  return 32'h0050_0093;
      32'h84:  return 32'h00a0_0113;
      32'h88:  return 32'h00f0_0193;
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Burst bookkeeping
  logic [31:0] rd_addrs[4];
  int          nrd, nen, cnt, fe_left;
  logic        outstanding;
  logic [31:0] cur_addr;

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; fetch_enable = 1'b0; jump_strobe = 1'b0;
    jump_addr = '0; mem_read_ack = 1'b0; mem_data = '0;

    //        fe js ja            sr ack data           rd addr          en ir            iro           pc            b  m  i
    tbl[0]  = v(1,0,32'h0,        0,0, 32'h0,          1,32'h80,       0,32'h0,       32'h0,       32'h0,       1,0,0);
    tbl[1]  = v(0,0,32'h0,        0,0, 32'h0,          0,32'h0,        0,32'h0,       32'h0,       32'h0,       1,0,0);
    tbl[2]  = v(0,0,32'h0,        0,1, 32'h00500093,   0,32'h0,        1,32'h00500093,32'h00500093,32'h80,      0,0,0);
    tbl[3]  = v(1,0,32'h0,        0,0, 32'h0,          1,32'h84,       0,32'h00500093,32'h00500093,32'h80,      1,0,0);
    tbl[4]  = v(0,1,32'h200,      0,0, 32'h0,          0,32'h0,        0,32'h00500093,32'h00500093,32'h80,      1,0,0);
    tbl[5]  = v(0,0,32'h0,        0,1, 32'h00a00113,   0,32'h0,        0,32'h00500093,32'h00500093,32'h80,      0,0,0);
    tbl[6]  = v(1,0,32'h0,        0,0, 32'h0,          1,32'h200,      0,32'h00500093,32'h00500093,32'h80,      1,0,0);
    tbl[7]  = v(0,0,32'h0,        0,1, 32'h00100073,   0,32'h0,        1,32'h00100073,32'h00100073,32'h200,     0,0,0);
    tbl[8]  = v(1,1,32'h202,      0,0, 32'h0,          0,32'h0,        0,32'h00100073,32'h00100073,32'h200,     0,1,0);
    tbl[9]  = v(0,0,32'h0,        0,0, 32'h0,          0,32'h0,        0,32'h00100073,32'h00100073,32'h200,     0,0,0);
    tbl[10] = v(0,1,32'h300,      0,0, 32'h0,          0,32'h0,        0,32'h00100073,32'h00100073,32'h200,     0,0,0);
    tbl[11] = v(1,0,32'h0,        0,0, 32'h0,          1,32'h300,      0,32'h00100073,32'h00100073,32'h200,     1,0,0);
    tbl[12] = v(0,0,32'h0,        0,1, 32'h00004501,   0,32'h0,        1,32'h00000013,32'h00004501,32'h300,     0,0,1);
    tbl[13] = v(0,0,32'h0,        0,0, 32'h0,          0,32'h0,        0,32'h00000013,32'h00004501,32'h300,     0,0,0);
    tbl[14] = v(0,0,32'h0,        0,1, 32'hdeadbeef,   0,32'h0,        0,32'h00000013,32'h00004501,32'h300,     0,0,0);
    tbl[15] = v(1,0,32'h0,        0,0, 32'h0,          1,32'h304,      0,32'h00000013,32'h00004501,32'h300,     1,0,0);
    tbl[16] = v(0,0,32'h0,        1,0, 32'h0,          0,32'h0,        0,32'h0,       32'h0,       32'h0,       0,0,0);
    tbl[17] = v(0,0,32'h0,        0,1, 32'h00c00213,   0,32'h0,        0,32'h0,       32'h0,       32'h0,       0,0,0);
    tbl[18] = v(1,0,32'h0,        0,0, 32'h0,          1,32'h80,       0,32'h0,       32'h0,       32'h0,       1,0,0);
    tbl[19] = v(0,0,32'h0,        0,1, 32'h00500093,   0,32'h0,        1,32'h00500093,32'h00500093,32'h80,      0,0,0);
    tbl[20] = v(1,0,32'h0,        0,0, 32'h0,          1,32'h84,       0,32'h00500093,32'h00500093,32'h80,      1,0,0);
    tbl[21] = v(0,1,32'h400,      0,1, 32'h00a00113,   0,32'h0,        0,32'h00500093,32'h00500093,32'h80,      0,0,0);
    tbl[22] = v(1,0,32'h0,        0,0, 32'h0,          1,32'h400,      0,32'h00500093,32'h00500093,32'h80,      1,0,0);
    tbl[23] = v(0,0,32'h0,        0,1, 32'h00000033,   0,32'h0,        1,32'h00000033,32'h00000033,32'h400,     0,0,0);
    tbl[24] = v(1,1,32'hfffffffc, 0,0, 32'h0,          1,32'hfffffffc, 0,32'h00000033,32'h00000033,32'h400,     1,0,0);
    tbl[25] = v(0,0,32'h0,        0,1, 32'h00000013,   0,32'h0,        1,32'h00000013,32'h00000013,32'hfffffffc,0,0,0);
    tbl[26] = v(1,0,32'h0,        0,0, 32'h0,          1,32'h0,        0,32'h00000013,32'h00000013,32'hfffffffc,1,0,0);
    tbl[27] = v(0,0,32'h0,        0,1, 32'h00000093,   0,32'h0,        1,32'h00000093,32'h00000093,32'h0,       0,0,0);

    // Reset state
    row = -1;
    #22;
    chk("reset mem_read_en", {31'b0, mem_read_en}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset enable_out", {31'b0, enable_out}, 32'h0);
    chk("reset IR_out", IR_out, 32'h0);
    chk("reset IR_original_out", IR_original_out, 32'h0);
    chk("reset PC_out", PC_out, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset exceptions", {30'b0, exception_misaligned, exception_illegal}, 32'h0);
    tick();
    reset_n = 1'b1;

    // Table-driven single-request scenarios
    for (int i = 0; i < 28; i++) begin
      row = i;
      fetch_enable = tbl[i].fe; jump_strobe = tbl[i].js; jump_addr = tbl[i].ja;
      sync_reset = tbl[i].sr; mem_read_ack = tbl[i].ack; mem_data = tbl[i].data;
      tick();
      chk("mem_read_en", {31'b0, mem_read_en}, {31'b0, tbl[i].rd});
      if (tbl[i].rd) chk("mem_addr", mem_addr, tbl[i].addr);
      chk("enable_out", {31'b0, enable_out}, {31'b0, tbl[i].en});
      chk("IR_out", IR_out, tbl[i].ir);
      chk("IR_original_out", IR_original_out, tbl[i].iro);
      chk("PC_out", PC_out, tbl[i].pc);
      chk("busy", {31'b0, busy}, {31'b0, tbl[i].bsy});
      chk("exception_misaligned", {31'b0, exception_misaligned}, {31'b0, tbl[i].mis});
      chk("exception_illegal", {31'b0, exception_illegal}, {31'b0, tbl[i].ill});
    end
    fetch_enable = 1'b0; jump_strobe = 1'b0; sync_reset = 1'b0; mem_read_ack = 1'b0;

    // Burst: requests arriving while reads are outstanding, 4-cycle memory
    row = 100;
    reset_n = 1'b0;
    #1;
    chk("async reset busy", {31'b0, busy}, 32'h0);
    tick();
    reset_n = 1'b1;
    nrd = 0; nen = 0; cnt = 0; fe_left = 1; outstanding = 1'b0; cur_addr = '0;
    for (int c = 0; c < 40; c++) begin
      fetch_enable = (fe_left > 0);
      if (fe_left > 0) fe_left--;
      tick();
      mem_read_ack = 1'b0;
      if (enable_out) begin
        chk("burst PC_out", PC_out, 32'h80 + 32'(4 * nen));
        chk("burst IR_out", IR_out, word_at(PC_out));
        nen++;
        outstanding = 1'b0;
      end
      if (mem_read_en) begin
        if (nrd < 4) rd_addrs[nrd] = mem_addr;
        nrd++;
        cnt = 4;
        cur_addr = mem_addr;
        outstanding = 1'b1;
        // Second request is a two-cycle pulse; the extra cycle must be absorbed.
        if (nrd == 1) fe_left = 2;
        if (nrd == 2) fe_left = 1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_read_ack = 1'b1;
          mem_data = word_at(cur_addr);
        end
      end
      chk("burst busy", {31'b0, busy}, {31'b0, outstanding});
    end
    chk("burst read count", 32'(nrd), 32'd3);
    chk("burst enable count", 32'(nen), 32'd3);
    if (nrd >= 3) begin
      chk("burst read addr 0", rd_addrs[0], 32'h80);
      chk("burst read addr 1", rd_addrs[1], 32'h84);
      chk("burst read addr 2", rd_addrs[2], 32'h88);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rattlesnake_instruction_fetch.md
Name: rattlesnake_instruction_fetch

Overview:
Instruction fetch stage feeding the decode stage's enable_in / IR_in / IR_original_in / PC_in interface. It holds the architectural fetch PC and issues one memory read per controller fetch request. It returns the fetched word to decode as a single-cycle enable pulse, handles redirects from jumps, branches, traps and MRET, and flags misaligned or non-32-bit instruction encodings.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset / sync_reset
XLEN, 32, instruction word width
PC_BITWIDTH, 32, PC and memory address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous reset, same effect as reset_n
fetch_enable  in  1  controller request for the next instruction (1-cycle pulse)
jump_strobe  in  1  redirect request (branch/jump/trap/MRET)
jump_addr  in  PC_BITWIDTH  redirect target
mem_read_en  out  1  memory read request (1-cycle pulse)
mem_addr  out  PC_BITWIDTH  read address, valid when mem_read_en=1
mem_read_ack  in  1  read data valid (1-cycle pulse)
mem_data  in  XLEN  read data
enable_out  out  1  instruction valid to decode (1-cycle pulse)
IR_out  out  XLEN  instruction to decode
IR_original_out  out  XLEN  raw fetched word
PC_out  out  PC_BITWIDTH  address of IR_out
exception_misaligned  out  1  fetch PC[1:0]!=0 (1-cycle pulse)
exception_illegal  out  1  fetched word[1:0]!=2'b11 (1-cycle pulse)
busy  out  1  read outstanding

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous, active-low. sync_reset has identical effect, applied at the clock edge.
- Reset state: pc=RESET_PC, state=IDLE, pending=0, discard=0.
- Reset values: all outputs 0 (mem_addr=0, IR_out=0, IR_original_out=0, PC_out=0).
- Registered outputs: all of them. mem_read_en, enable_out and the exception outputs are pulses, high for exactly 1 cycle.
- States:
  - IDLE: no read outstanding, busy=0.
  - WAIT_ACK: read outstanding, busy=1.
- Target address: target = jump_strobe ? jump_addr : pc. jump_strobe always writes pc <= jump_addr, in either state.
- IDLE, fetch_enable=1 (or pending=1):
  - If target[1:0]!=0: pulse exception_misaligned next cycle, issue no read, stay IDLE, clear pending.
  - Otherwise: next cycle mem_read_en=1, mem_addr=target; latch fetch_addr=target; go to WAIT_ACK; clear pending.
- WAIT_ACK, mem_read_ack=1 with discard=0, next cycle:
  - enable_out=1, IR_original_out=mem_data, PC_out=fetch_addr.
  - IR_out=mem_data if mem_data[1:0]==2'b11; otherwise IR_out=32'h0000_0013 (NOP) and exception_illegal=1.
  - pc <= fetch_addr+4, modulo 2^PC_BITWIDTH (wraps to 0 from all-ones-minus-3), unless jump_strobe is also high that cycle, in which case pc <= jump_addr.
  - Return to IDLE.
- WAIT_ACK, jump_strobe=1: set discard=1.
  - The next ack is consumed silently: no enable_out, no exception, pc unchanged by it. discard clears on that ack.
  - jump_strobe in the same cycle as the ack is also a discard: the returned word is dropped, pc=jump_addr.
- WAIT_ACK, fetch_enable=1: sets pending=1 (depth 1; further requests while pending are absorbed).
  - On return to IDLE, the pending fetch issues on the following cycle without a new fetch_enable.
- Latency:
  - fetch_enable to mem_read_en: 1 cycle.
  - mem_read_ack to enable_out: 1 cycle.
  - Minimum fetch_enable to enable_out: 3 cycles with a 1-cycle memory.
- mem_read_ack while in IDLE is ignored.
- Outputs IR_out, IR_original_out and PC_out hold their values between enable_out pulses.
- Reset mid-operation (reset_n or sync_reset during WAIT_ACK): returns to IDLE with discard=0; any later ack for the old request is ignored as an IDLE ack.

Test Plan:
- Reset, RESET_PC=0x80, fetch_enable, memory acks 1 cycle after the request with 0x00500093 -> mem_read_en@T+1 with mem_addr=0x80; enable_out@T+3 with IR_out=IR_original_out=0x00500093, PC_out=0x80; next fetch reads 0x84.
- Three back-to-back fetch_enable pulses with 4-cycle memory latency -> exactly 3 reads at 0x80, 0x84, 0x88, 3 enable_out pulses, pending honoured; busy high while each read is outstanding.
- jump_strobe with jump_addr=0x200 during WAIT_ACK for 0x84 -> ack for 0x84 dropped (no enable_out); next fetch reads 0x200, PC_out=0x200.
- jump_strobe with jump_addr=0x202 together with fetch_enable in IDLE -> exception_misaligned pulse, no mem_read_en, busy=0.
- Memory returns 0x0000_4501 -> exception_illegal=1, IR_out=0x00000013, IR_original_out=0x00004501, enable_out=1.
- sync_reset asserted in WAIT_ACK followed by a late ack -> no enable_out; next fetch uses RESET_PC.
